// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared constants and types for the alu_seq_unit block:
//   - ALUOp encodings driven by the main control unit
//   - R-type funct codes recognised by the decoder
//   - internal 4-bit ALUOperation codes
//   - sequencer FSM state enum
// Configuration macro: ALU_SEQ_DIV_EN (adds the DIV state when defined).
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    // ALUOp from the main control unit
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // R-type funct field codes
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    // Internal ALUOperation codes; the first five keep the classic MIPS values.
    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MFHI = 4'b1000,
        OP_MFLO = 4'b1001,
        OP_MUL  = 4'b1010,
        OP_DIV  = 4'b1011,
        OP_NONE = 4'b1111
    } alu_operation_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01
`ifdef ALU_SEQ_DIV_EN
        ,
        ST_DIV  = 2'b10
`endif
    } state_e;

endpackage

// File: rtl/alu_seq_decode.sv
// -----------------------------------------------------------------------------
// alu_seq_decode
// Combinational ALU control: maps ALUOp/funct to an internal ALUOperation code
// and flags operations that need the iterative datapath.
// Ports:
//   alu_op_i  [1:0]  ALUOp from main control
//   funct_i   [5:0]  R-type funct field
//   alu_ctl_o [3:0]  ALUOperation code (OP_NONE for unknown/reserved)
//   multi_o          high for multu (and divu when ALU_SEQ_DIV_EN is defined)
// Configuration macro: ALU_SEQ_DIV_EN (divu decodes as unknown when undefined).
// -----------------------------------------------------------------------------
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctl_o,
    output logic       multi_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        alu_ctl_o = OP_NONE;
        multi_o   = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: alu_ctl_o = OP_ADD;
            ALUOP_SUB: alu_ctl_o = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD:  alu_ctl_o = OP_ADD;
                    FUNCT_SUB:  alu_ctl_o = OP_SUB;
                    FUNCT_AND:  alu_ctl_o = OP_AND;
                    FUNCT_OR:   alu_ctl_o = OP_OR;
                    FUNCT_SLT:  alu_ctl_o = OP_SLT;
                    FUNCT_MFHI: alu_ctl_o = OP_MFHI;
                    FUNCT_MFLO: alu_ctl_o = OP_MFLO;
                    FUNCT_MULTU: begin
                        alu_ctl_o = OP_MUL;
                        multi_o   = 1'b1;
                    end
`ifdef ALU_SEQ_DIV_EN
                    FUNCT_DIVU: begin
                        alu_ctl_o = OP_DIV;
                        multi_o   = 1'b1;
                    end
`endif
                    default: alu_ctl_o = OP_NONE;
                endcase
            end
            default: alu_ctl_o = OP_NONE;  // ALUOp 11 is reserved
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
// MIPS ALU + ALU control with a start/busy/done handshake. Logic/arithmetic ops
// complete in one registered cycle; multu (and optionally divu) iterate one bit
// per cycle into the HI/LO registers.
// Ports:
//   clk, reset (async, active-high)
//   start            launch an op (sampled only in IDLE)
//   ALUOp[1:0], funct[5:0], a, b   operation and operands
//   busy             multi-cycle op in flight
//   done             one-cycle completion pulse
//   result, zero     registered result and its zero flag
//   hi, lo           HI/LO registers
// Configuration macro: ALU_SEQ_DIV_EN (enables divu / DIV state).
// -----------------------------------------------------------------------------
module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Shared iteration register: {partial product} for multu, {rem, quotient} for divu.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Latched multiplicand (multu) or divisor (divu).
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic               zero_q, zero_d, done_q, done_d;

    logic [3:0]         alu_ctl;
    logic               multi;
    logic               res_load;
    logic [WIDTH-1:0]   res_val;

    alu_seq_decode u_decode (
        .alu_op_i  (ALUOp),
        .funct_i   (funct),
        .alu_ctl_o (alu_ctl),
        .multi_o   (multi)
    );

    // Right-shifting shift-add step: add the multiplicand into the upper half
    // when the current multiplier bit (acc LSB) is set, then shift right by one.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    // Restoring step: shift the next dividend bit into the remainder and try to
    // subtract. When the subtraction succeeds the true difference is below the
    // divisor, so a WIDTH-bit subtract is exact.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        res_load = 1'b0;
        res_val  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (multi && (alu_ctl == OP_MUL)) begin
                        state_d = ST_MUL;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, b};
                        opnd_d  = a;
`ifdef ALU_SEQ_DIV_EN
                    end else if (multi && (b == '0)) begin
                        // Divide by zero bypasses the iteration entirely.
                        lo_d     = '1;
                        hi_d     = a;
                        res_load = 1'b1;
                        res_val  = '1;
                    end else if (multi) begin
                        state_d = ST_DIV;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, a};
                        opnd_d  = b;
`endif
                    end else begin
                        res_load = 1'b1;
                        case (alu_ctl)
                            OP_ADD:  res_val = a + b;
                            OP_SUB:  res_val = a - b;
                            OP_AND:  res_val = a & b;
                            OP_OR:   res_val = a | b;
                            OP_SLT:  res_val = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                            OP_MFHI: res_val = hi_q;
                            OP_MFLO: res_val = lo_q;
                            default: res_val = '0;
                        endcase
                    end
                end
            end
            ST_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST) begin
                    state_d  = ST_IDLE;
                    hi_d     = mul_next[2*WIDTH-1:WIDTH];
                    lo_d     = mul_next[WIDTH-1:0];
                    res_load = 1'b1;
                    res_val  = mul_next[WIDTH-1:0];
                end
            end
`ifdef ALU_SEQ_DIV_EN
            ST_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST) begin
                    state_d  = ST_IDLE;
                    hi_d     = div_next[2*WIDTH-1:WIDTH];
                    lo_d     = div_next[WIDTH-1:0];
                    res_load = 1'b1;
                    res_val  = div_next[WIDTH-1:0];
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (res_load) begin
            result_d = res_val;
            zero_d   = (res_val == '0);
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_unit
// Self-checking bench for alu_seq_unit: a WIDTH=32 and a WIDTH=8 instance share
// clock and reset. Expected results come from an independent behavioural model,
// are queued when an op is launched and popped when done is observed.
// Honours ALU_SEQ_DIV_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_seq_unit;

`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        start32, busy32, done32, zero32;
    logic [1:0]  op32;
    logic [5:0]  f32;
    logic [31:0] a32, b32, res32, hi32, lo32;

    logic        start8, busy8, done8, zero8;
    logic [1:0]  op8;
    logic [5:0]  f8;
    logic [7:0]  a8, b8, res8, hi8, lo8;

    alu_seq_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start32), .ALUOp(op32), .funct(f32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .result(res32),
        .zero(zero32), .hi(hi32), .lo(lo32)
    );

    alu_seq_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .ALUOp(op8), .funct(f8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8),
        .zero(zero8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [63:0] result;
        logic        zero;
        logic [63:0] hi;
        logic [63:0] lo;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] m_hi32 = '0, m_lo32 = '0, m_hi8 = '0, m_lo8 = '0;

    // Behavioural reference model for one operation at width w (w <= 32).
    task automatic predict(input int w, input logic [1:0] op, input logic [5:0] f,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] hi_in, input logic [63:0] lo_in,
                           output exp_t e);
        logic [63:0]        mask, am, bm, r, p;
        logic signed [63:0] sa, sb;
        mask = (64'd1 << w) - 64'd1;
        am   = a & mask;
        bm   = b & mask;
        sa   = $signed(am << (64 - w)) >>> (64 - w);
        sb   = $signed(bm << (64 - w)) >>> (64 - w);
        e.hi = hi_in;
        e.lo = lo_in;
        e.lat = 0;
        r = '0;
        if (op == 2'b00) r = am + bm;
        else if (op == 2'b01) r = am - bm;
        else if (op == 2'b10) begin
            case (f)
                6'b100000: r = am + bm;
                6'b100010: r = am - bm;
                6'b100100: r = am & bm;
                6'b100101: r = am | bm;
                6'b101010: r = (sa < sb) ? 64'd1 : 64'd0;
                6'b010000: r = hi_in;
                6'b010010: r = lo_in;
                6'b011001: begin
                    p = am * bm;
                    e.hi = (p >> w) & mask;
                    e.lo = p & mask;
                    r = e.lo;
                    e.lat = w;
                end
                6'b011011: begin
                    if (DIV_EN) begin
                        if (bm == 0) begin
                            e.lo = mask;
                            e.hi = am;
                        end else begin
                            e.lo = am / bm;
                            e.hi = am % bm;
                            e.lat = w;
                        end
                        r = e.lo;
                    end
                end
                default: r = '0;
            endcase
        end
        r = r & mask;
        e.result = r;
        e.zero = (r == 0);
    endtask

    task automatic drive(input int w, input logic s, input logic [1:0] op, input logic [5:0] f,
                         input logic [63:0] a, input logic [63:0] b);
        if (w == 8) begin
            start8 = s; op8 = op; f8 = f; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = s; op32 = op; f32 = f; a32 = a[31:0]; b32 = b[31:0];
        end
    endtask

    task automatic sample(input int w, output logic d, output logic bsy, output logic z,
                          output logic [63:0] r, output logic [63:0] h, output logic [63:0] l);
        if (w == 8) begin
            d = done8; bsy = busy8; z = zero8;
            r = {56'b0, res8}; h = {56'b0, hi8}; l = {56'b0, lo8};
        end else begin
            d = done32; bsy = busy32; z = zero32;
            r = {32'b0, res32}; h = {32'b0, hi32}; l = {32'b0, lo32};
        end
    endtask

    // Launch one op, optionally pulse a spurious start (with altered inputs)
    // inject_at cycles into a busy period, then check the completion.
    task automatic run_op(input int w, input logic [1:0] op, input logic [5:0] f,
                          input logic [63:0] a, input logic [63:0] b,
                          input int inject_at, input string name);
        exp_t        e, got;
        logic        d, bsy, z;
        logic [63:0] r, h, l;
        int          n;
        bit          busy_ok;
        if (w == 8) begin
            predict(8, op, f, a, b, m_hi8, m_lo8, e);
            m_hi8 = e.hi; m_lo8 = e.lo;
        end else begin
            predict(32, op, f, a, b, m_hi32, m_lo32, e);
            m_hi32 = e.hi; m_lo32 = e.lo;
        end
        exp_q.push_back(e);
        @(negedge clk); drive(w, 1'b1, op, f, a, b);
        @(negedge clk); drive(w, 1'b0, op, f, a, b);
        n = 0;
        busy_ok = 1'b1;
        sample(w, d, bsy, z, r, h, l);
        while (!d && n < w + 8) begin
            if (bsy !== 1'b1) busy_ok = 1'b0;
            if (n == inject_at) drive(w, 1'b1, 2'b00, 6'b000000, ~a, ~b);
            else drive(w, 1'b0, op, f, ~a, b);
            @(negedge clk);
            n++;
            sample(w, d, bsy, z, r, h, l);
        end
        drive(w, 1'b0, op, f, a, b);
        got = exp_q.pop_front();
        n_cmp++;
        if (d !== 1'b1) begin
            $display("FAIL %s timeout: no done after %0d cycles, required latency %0d", name, n, got.lat);
            n_err++;
            return;
        end
        n_cmp++;
        if (r !== got.result) begin
            $display("FAIL %s result: got %h required %h", name, r, got.result); n_err++;
        end
        n_cmp++;
        if (z !== got.zero) begin
            $display("FAIL %s zero: got %b required %b", name, z, got.zero); n_err++;
        end
        n_cmp++;
        if (h !== got.hi || l !== got.lo) begin
            $display("FAIL %s hi/lo: got %h/%h required %h/%h", name, h, l, got.hi, got.lo); n_err++;
        end
        n_cmp++;
        if (n != got.lat) begin
            $display("FAIL %s latency: got %0d required %0d", name, n, got.lat); n_err++;
        end
        n_cmp++;
        if (bsy !== 1'b0 || !busy_ok) begin
            $display("FAIL %s busy: at done %b, held-high-while-waiting %0d required 0/1", name, bsy, busy_ok); n_err++;
        end
        // done must be a single pulse and an ignored start must not be queued
        repeat (2) begin
            @(negedge clk);
            sample(w, d, bsy, z, r, h, l);
            n_cmp++;
            if (d !== 1'b0 || bsy !== 1'b0) begin
                $display("FAIL %s after-done: done %b busy %b required 0 0", name, d, bsy); n_err++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(32, 1'b0, 2'b00, 6'b0, 64'd0, 64'd0);
        drive(8, 1'b0, 2'b00, 6'b0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy32, done32, zero32, res32, hi32, lo32} !== '0) begin
            $display("FAIL reset32: busy %b done %b zero %b result %h hi %h lo %h required all 0",
                     busy32, done32, zero32, res32, hi32, lo32); n_err++;
        end
        n_cmp++;
        if ({busy8, done8, zero8, res8, hi8, lo8} !== '0) begin
            $display("FAIL reset8: busy %b done %b zero %b result %h hi %h lo %h required all 0",
                     busy8, done8, zero8, res8, hi8, lo8); n_err++;
        end
    endtask

    task automatic test_single;
        run_op(32, 2'b10, 6'b100010, 64'd5, 64'd7, -1, "sub_5_7");
        run_op(32, 2'b10, 6'b101010, 64'hFFFFFFFF, 64'd1, -1, "slt_neg");
        run_op(32, 2'b10, 6'b101010, 64'd1, 64'hFFFFFFFF, -1, "slt_pos");
        run_op(32, 2'b00, 6'b111111, 64'd3, 64'hFFFFFFFD, -1, "add_wrap_zero");
        run_op(32, 2'b01, 6'b000000, 64'd0, 64'd1, -1, "aluop_sub");
        run_op(32, 2'b10, 6'b100100, 64'hF0F0_1234, 64'h0FF0_FF00, -1, "and");
        run_op(32, 2'b10, 6'b100101, 64'hF000_0001, 64'h0000_8000, -1, "or");
        run_op(32, 2'b10, 6'b100000, 64'hFFFF_FFFF, 64'd2, -1, "add_wrap");
        run_op(32, 2'b11, 6'b100000, 64'd9, 64'd9, -1, "aluop_reserved");
        run_op(32, 2'b10, 6'b111111, 64'd9, 64'd9, -1, "funct_unknown");
    endtask

    task automatic test_multu;
        run_op(32, 2'b10, 6'b011001, 64'hFFFFFFFF, 64'd2, 4, "multu_ff_x2");
        run_op(32, 2'b10, 6'b010000, 64'd0, 64'd0, -1, "mfhi_after_multu");
        run_op(32, 2'b10, 6'b010010, 64'd0, 64'd0, -1, "mflo_after_multu");
        for (int i = 0; i < 2; i++)
            run_op(32, 2'b10, 6'b011001, {32'b0, $urandom}, {32'b0, $urandom}, -1, "multu_rand");
        run_op(32, 2'b10, 6'b011001, 64'hFFFFFFFF, 64'hFFFFFFFF, -1, "multu_max");
    endtask

    task automatic test_divu;
        run_op(32, 2'b10, 6'b011011, 64'd100, 64'd7, 3, "divu_100_7");
        run_op(32, 2'b10, 6'b011011, 64'd9, 64'd0, -1, "divu_by_zero");
        run_op(32, 2'b10, 6'b011011, 64'hFFFFFFFF, 64'd16, -1, "divu_big");
        run_op(32, 2'b10, 6'b010000, 64'd0, 64'd0, -1, "mfhi_after_divu");
    endtask

    task automatic test_width8;
        run_op(8, 2'b10, 6'b011001, 64'd200, 64'd3, -1, "w8_multu_200_3");
        run_op(8, 2'b10, 6'b010000, 64'd0, 64'd0, -1, "w8_mfhi");
        run_op(8, 2'b10, 6'b101010, 64'h80, 64'h7F, -1, "w8_slt");
        run_op(8, 2'b00, 6'b000000, 64'hF0, 64'h20, -1, "w8_add_wrap");
    endtask

    // Second start is presented while done of the first is high.
    task automatic test_back_to_back;
        exp_t e1, e2, got;
        predict(32, 2'b00, 6'b0, 64'd10, 64'd20, m_hi32, m_lo32, e1);
        predict(32, 2'b01, 6'b0, 64'd77, 64'd77, m_hi32, m_lo32, e2);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        @(negedge clk); drive(32, 1'b1, 2'b00, 6'b0, 64'd10, 64'd20);
        @(negedge clk);
        got = exp_q.pop_front();
        n_cmp++;
        if (done32 !== 1'b1 || {32'b0, res32} !== got.result) begin
            $display("FAIL b2b_first: done %b result %h required 1 %h", done32, res32, got.result); n_err++;
        end
        drive(32, 1'b1, 2'b01, 6'b0, 64'd77, 64'd77);
        @(negedge clk);
        drive(32, 1'b0, 2'b00, 6'b0, 64'd0, 64'd0);
        got = exp_q.pop_front();
        n_cmp++;
        if (done32 !== 1'b1 || {32'b0, res32} !== got.result || zero32 !== got.zero) begin
            $display("FAIL b2b_second: done %b result %h zero %b required 1 %h %b",
                     done32, res32, zero32, got.result, got.zero); n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if (done32 !== 1'b0) begin
            $display("FAIL b2b_tail: done %b required 0", done32); n_err++;
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        @(negedge clk); drive(32, 1'b1, 2'b10, 6'b011001, 64'd12345, 64'd678);
        @(negedge clk); drive(32, 1'b0, 2'b10, 6'b011001, 64'd12345, 64'd678);
        repeat (9) @(negedge clk);
        n_cmp++;
        if (busy32 !== 1'b1) begin
            $display("FAIL reset_mid_pre: busy %b required 1", busy32); n_err++;
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy32, done32, res32, hi32, lo32} !== '0) begin
            $display("FAIL reset_mid_clear: busy %b done %b result %h hi %h lo %h required all 0",
                     busy32, done32, res32, hi32, lo32); n_err++;
        end
        @(negedge clk);
        reset = 1'b0;
        m_hi32 = '0; m_lo32 = '0; m_hi8 = '0; m_lo8 = '0;
        exp_q.delete();
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 === 1'b1 || busy32 === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            $display("FAIL reset_mid_no_done: %0d cycles with done/busy, required 0", dones); n_err++;
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_multu;
        test_divu;
        test_width8;
        test_back_to_back;
        test_reset_mid;
        run_op(32, 2'b10, 6'b010000, 64'd0, 64'd0, -1, "mfhi_after_reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised ALU and ALU-control block for the single-cycle/multi-cycle MIPS datapath. It decodes `ALUOp`/`funct` internally, then executes one of two operation classes:

- logic/arithmetic ops, completing in one registered cycle;
- unsigned multiply/divide, computed iteratively into HI/LO registers.

The block sits between the register file read ports and the writeback mux. It uses a start/busy/done handshake so the control FSM can stall on long operations.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width. Legal range 4 to 64.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  launches an operation. Sampled only in IDLE.
- `ALUOp`  in  2  00 = add, 01 = sub, 10 = decode `funct`, 11 = reserved.
- `funct`  in  6  R-type function field.
- `a`, `b`  in  WIDTH  operands.
- `busy`  out  1  high while a multi-cycle op is in flight.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result`  out  WIDTH  registered result. Held until the next completion.
- `zero`  out  1  `result == 0`, registered with `result`.
- `hi`, `lo`  out  WIDTH  HI/LO registers.

## Operation
- Reset value of every output is 0. HI and LO are 0; the FSM is in IDLE.
- FSM states are IDLE, MUL, DIV.
- Single-cycle ops. On `start` in IDLE, the result is registered and `done` pulses; the FSM stays in IDLE.
  - add (ALUOp 00, funct 100000)
  - sub (ALUOp 01, funct 100010)
  - and (100100)
  - or (100101)
  - slt (101010): signed compare. The result is 1 or 0, zero-extended.
  - mfhi (010000): `result = hi`.
  - mflo (010010): `result = lo`.
- Unknown funct or ALUOp 11: `result = 0`, `done` still pulses, HI/LO unchanged.
- add/sub wrap modulo 2^WIDTH. No overflow flag.
- multu (011001): IDLE → MUL. Shift-add over WIDTH iterations, one bit per cycle, with a 2·WIDTH-bit product. On the last iteration: `{hi,lo} = a*b`, `result = lo`, `done` pulses, FSM returns to IDLE.
- divu (011011): IDLE → DIV. Restoring division over WIDTH iterations. On completion: `lo` = quotient, `hi` = remainder, `result = lo`.
- Division by zero: DIV is skipped. `lo` = all ones, `hi = a`, `done` pulses the cycle after `start` (same latency as single-cycle ops).
- Operands and op are latched on `start`. Input changes while busy have no effect.
- `start` while busy is ignored and not queued.
- `start` in the same cycle `done` is high is accepted, because the FSM is already in IDLE.
- Reset mid-operation: the FSM immediately returns to IDLE, HI/LO/result clear, and no `done` is produced.

## Timing
- Cycle 0 is the edge sampling `start`.
- Single-cycle ops: `done`, `result` and `zero` are valid after edge 0 (latency 1).
- multu/divu: `busy` is high after edges 0 through WIDTH−1. `done` is high after edge WIDTH, with HI, LO and `result` updated at the same edge. Latency is WIDTH+1 cycles; `busy` is low in the `done` cycle.
- `done` is high for exactly one cycle per accepted `start`.
- No combinational path from inputs to outputs.

## Configuration
- `ALU_SEQ_DIV_EN` defined: divu and the DIV state are implemented as above.
- `ALU_SEQ_DIV_EN` undefined: divu is treated as an unknown funct, with `result = 0`, single-cycle `done`, and HI/LO unchanged. The DIV state and divider datapath are absent.

## Structure
- Package `alu_seq_pkg` holds:
  - ALUOp constants;
  - funct codes (add, sub, and, or, slt, mfhi, mflo, multu, divu);
  - the 4-bit internal ALUOperation codes: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, plus new codes for mfhi, mflo, mul and div;
  - the FSM state enum.
- One sub-module, `alu_seq_decode`: combinational ALUOp/funct → ALUOperation plus a multi-cycle flag. Instantiated once.
- The iterative datapath stays in the top module.

## Test plan
- WIDTH=32, ALUOp 10, funct 100010, a=5, b=7, `start` → after 1 cycle `result`=0xFFFFFFFE, `zero`=0, `done` pulse of one cycle.
- ALUOp 10, funct 101010, a=0xFFFFFFFF, b=1 → `result`=1. Then ALUOp 00, a=3, b=0xFFFFFFFD → `result`=0, `zero`=1.
- multu a=0xFFFFFFFF, b=2 → `busy` for 32 cycles, `done` at cycle 33, `hi`=1, `lo`=0xFFFFFFFE. A second `start` at cycle 5 is ignored.
- With `ALU_SEQ_DIV_EN`: divu a=100, b=7 → `lo`=14, `hi`=2 at cycle 33. divu with b=0, a=9 → `lo`=0xFFFFFFFF, `hi`=9, `done` after 1 cycle.
- WIDTH=8: multu a=200, b=3 → `hi`=0x02, `lo`=0x58 at cycle 9. Then mfhi → `result`=0x02.
- Assert `reset` at cycle 10 of a multu → `busy`, `hi`, `lo` and `result` are 0 immediately, and no `done` follows.
